// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : cpu_pkg                                                    |
// | Shared types and constants for the 5-stage pipeline control logic.  |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
package cpu_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    localparam logic [4:0] XZR = 5'd31;

    // The EX-stage producer is younger than the MEM-stage one, so it wins.
    function automatic fwd_sel_t fwd_pick(input logic ex_hit, input logic mem_hit);
        fwd_sel_t sel;
        sel = FWD_RF;
        if (ex_hit) begin
            sel = FWD_MEM;
        end else if (mem_hit) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_src_cmp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : hazard_src_cmp                                             |
// | Compares one source register against one pipeline stage's writer.    |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module hazard_src_cmp
    import cpu_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] src,
    input  logic          use_src,
    input  logic          stg_valid,
    input  logic          stg_regw,
    input  logic [AW-1:0] stg_rd,
    output logic          match
);

    // XZR reads as zero and is never a real dependency.
    assign match = use_src & stg_valid & stg_regw
                 & (stg_rd == src) & (src != AW'(XZR));

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fwd_hazard_ctrl                                            |
// | Forwarding-select and load-use stall control with EX/MEM shadow regs.|
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module fwd_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int AW   = 5,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rn,
    input  logic [AW-1:0]   id_rm,
    input  logic [AW-1:0]   id_rd,
    input  logic            id_reg2loc,
    input  logic            id_uses_a,
    input  logic            id_uses_b,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            flush,
    output logic [AW-1:0]   rd_addr_b,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic            stall,
    output logic [CNTW-1:0] stall_cnt
);

    logic            r_ex_valid;
    logic            r_ex_regw;
    logic            r_ex_memrd;
    logic [AW-1:0]   r_ex_rd;
    logic            r_mem_valid;
    logic            r_mem_regw;
    logic [AW-1:0]   r_mem_rd;
    fwd_sel_t        r_fwd_a;
    fwd_sel_t        r_fwd_b;
    logic [CNTW-1:0] r_stall_cnt;

    logic [AW-1:0]   w_rd_addr_b;
    logic [AW-1:0]   w_src     [2];
    logic [1:0]      w_use;
    logic [1:0]      w_stg_valid;
    logic [1:0]      w_stg_regw;
    logic [AW-1:0]   w_stg_rd  [2];
    logic [3:0]      w_match;
    logic            w_ex_hit_a;
    logic            w_mem_hit_a;
    logic            w_ex_hit_b;
    logic            w_mem_hit_b;
    logic            w_stall;
    logic            w_accept;

    assign w_rd_addr_b = id_reg2loc ? id_rd : id_rm;

    assign w_src[0]       = id_rn;
    assign w_src[1]       = w_rd_addr_b;
    assign w_use          = {id_uses_b, id_uses_a};
    assign w_stg_valid    = {r_mem_valid, r_ex_valid};
    assign w_stg_regw     = {r_mem_regw, r_ex_regw};
    assign w_stg_rd[0]    = r_ex_rd;
    assign w_stg_rd[1]    = r_mem_rd;

    // Match index = source*2 + stage, stage 0 = EX, stage 1 = MEM.
    generate
        for (genvar s = 0; s < 2; s++) begin : g_src
            for (genvar t = 0; t < 2; t++) begin : g_stg
                hazard_src_cmp #(
                    .AW (AW)
                ) u_cmp (
                    .src       (w_src[s]),
                    .use_src   (w_use[s]),
                    .stg_valid (w_stg_valid[t]),
                    .stg_regw  (w_stg_regw[t]),
                    .stg_rd    (w_stg_rd[t]),
                    .match     (w_match[s*2+t])
                );
            end
        end
    endgenerate

    assign w_ex_hit_a  = w_match[0];
    assign w_mem_hit_a = w_match[1];
    assign w_ex_hit_b  = w_match[2];
    assign w_mem_hit_b = w_match[3];

    // A load in EX cannot forward yet; hold ID one cycle until it reaches MEM.
    assign w_stall  = id_valid & ~flush & r_ex_valid & r_ex_memrd & r_ex_regw
                    & (w_ex_hit_a | w_ex_hit_b);
    assign w_accept = id_valid & ~flush & ~w_stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ex_valid  <= 1'b0;
            r_ex_regw   <= 1'b0;
            r_ex_memrd  <= 1'b0;
            r_ex_rd     <= '0;
            r_mem_valid <= 1'b0;
            r_mem_regw  <= 1'b0;
            r_mem_rd    <= '0;
            r_fwd_a     <= FWD_RF;
            r_fwd_b     <= FWD_RF;
            r_stall_cnt <= '0;
        end else begin
            r_mem_valid <= r_ex_valid;
            r_mem_regw  <= r_ex_regw;
            r_mem_rd    <= r_ex_rd;
            r_ex_valid  <= w_accept;
            r_ex_regw   <= w_accept & id_reg_write;
            r_ex_memrd  <= w_accept & id_mem_read;
            r_ex_rd     <= id_rd;
            r_fwd_a     <= w_accept ? fwd_pick(w_ex_hit_a, w_mem_hit_a) : FWD_RF;
            r_fwd_b     <= w_accept ? fwd_pick(w_ex_hit_b, w_mem_hit_b) : FWD_RF;
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNTW'(1);
            end
        end
    end

    assign rd_addr_b = w_rd_addr_b;
    assign fwd_a     = r_fwd_a;
    assign fwd_b     = r_fwd_b;
    assign stall     = w_stall;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_fwd_hazard_ctrl                                         |
// | Directed table, reset/saturation sequences and random model checks.  |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module tb_fwd_hazard_ctrl;

    localparam int AW   = 5;
    localparam int CNTW = 10;

    logic            clk = 1'b0;
    logic            reset;
    logic            id_valid, id_reg2loc, id_uses_a, id_uses_b;
    logic            id_reg_write, id_mem_read, flush;
    logic [AW-1:0]   id_rn, id_rm, id_rd;
    logic [AW-1:0]   rd_addr_b;
    logic [1:0]      fwd_a, fwd_b;
    logic            stall;
    logic [CNTW-1:0] stall_cnt;

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.AW(AW), .CNTW(CNTW)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rn        (id_rn),
        .id_rm        (id_rm),
        .id_rd        (id_rd),
        .id_reg2loc   (id_reg2loc),
        .id_uses_a    (id_uses_a),
        .id_uses_b    (id_uses_b),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .rd_addr_b    (rd_addr_b),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .stall        (stall),
        .stall_cnt    (stall_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       v;
        logic [4:0] rn, rm, rd;
        logic       r2l, ua, ub, rw, mr, fl;
        logic       e_stall;
        logic [4:0] e_rdb;
        logic [1:0] e_fa, e_fb;
        int         e_cnt;
    } vec_t;

    function automatic vec_t mk(input int v, rn, rm, rd, r2l, ua, ub, rw, mr, fl,
                                input int st, rdb, fa, fb, cnt);
        vec_t m;
        m.v = v[0]; m.rn = rn[4:0]; m.rm = rm[4:0]; m.rd = rd[4:0];
        m.r2l = r2l[0]; m.ua = ua[0]; m.ub = ub[0]; m.rw = rw[0];
        m.mr = mr[0]; m.fl = fl[0]; m.e_stall = st[0]; m.e_rdb = rdb[4:0];
        m.e_fa = fa[1:0]; m.e_fb = fb[1:0]; m.e_cnt = cnt;
        return m;
    endfunction

    task automatic drive(input vec_t m);
        id_valid = m.v; id_rn = m.rn; id_rm = m.rm; id_rd = m.rd;
        id_reg2loc = m.r2l; id_uses_a = m.ua; id_uses_b = m.ub;
        id_reg_write = m.rw; id_mem_read = m.mr; flush = m.fl;
    endtask

    // Reference model: the last two issue slots, newest at the back.
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } slot_t;

    slot_t hist[$];
    int    mcnt;

    function automatic int age_of(input logic [4:0] src);
        if (src == 5'd31) return 0;
        for (int a = 1; a <= 2; a++) begin
            slot_t s;
            s = hist[hist.size()-a];
            if (s.v && s.rw && s.rd == src) return a;
        end
        return 0;
    endfunction

    function automatic logic [1:0] sel_of(input logic used, input logic [4:0] src);
        int a;
        a = used ? age_of(src) : 0;
        return (a == 1) ? 2'b10 : (a == 2) ? 2'b01 : 2'b00;
    endfunction

    function automatic logic model_stall();
        slot_t n;
        logic [4:0] b;
        n = hist[hist.size()-1];
        b = id_reg2loc ? id_rd : id_rm;
        return id_valid && !flush && n.v && n.mr && n.rw &&
               ((id_uses_a && age_of(id_rn) == 1) || (id_uses_b && age_of(b) == 1));
    endfunction

    task automatic model_reset();
        hist.delete();
        hist.push_back('0);
        hist.push_back('0);
        mcnt = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
    endtask

    function automatic logic [4:0] pick_reg();
        int r;
        r = $urandom_range(0, 5);
        return (r == 5) ? 5'd31 : 5'(r);
    endfunction

    vec_t tbl[17];
    vec_t ldv, usev;

    initial begin
        //        v rn rm rd r2 ua ub rw mr fl  st rdb fa fb cnt
        tbl[0]  = mk(1, 5, 6, 1,0,1,1,1,0,0, 0, 6, 0,0,0);
        tbl[1]  = mk(1, 1, 3, 2,0,1,1,1,0,0, 0, 3, 2,0,0);
        tbl[2]  = mk(1, 5, 1, 4,0,1,1,1,0,0, 0, 1, 0,1,0);
        tbl[3]  = mk(1, 5, 6, 1,0,1,1,1,0,0, 0, 6, 0,0,0);
        tbl[4]  = mk(1, 1, 7, 1,0,1,1,1,0,0, 0, 7, 2,0,0);
        tbl[5]  = mk(1, 1, 1, 3,0,1,1,1,0,0, 0, 1, 2,2,0);
        tbl[6]  = mk(0, 0, 0, 0,0,0,0,0,0,0, 0, 0, 0,0,0);
        tbl[7]  = mk(1, 2, 0, 1,0,1,0,1,1,0, 0, 0, 0,0,0);
        tbl[8]  = mk(1, 1, 1, 2,0,1,1,1,0,0, 1, 1, 0,0,1);
        tbl[9]  = mk(1, 1, 1, 2,0,1,1,1,0,0, 0, 1, 1,1,1);
        tbl[10] = mk(1, 5, 6,31,0,1,1,1,0,0, 0, 6, 0,0,1);
        tbl[11] = mk(1,31,31, 9,0,1,1,1,0,0, 0,31, 0,0,1);
        tbl[12] = mk(1, 5, 6, 7,0,1,1,1,0,0, 0, 6, 0,0,1);
        tbl[13] = mk(1,10, 9, 7,1,1,1,0,0,0, 0, 7, 0,2,1);
        tbl[14] = mk(1, 5, 0, 4,0,1,0,1,1,0, 0, 0, 0,0,1);
        tbl[15] = mk(1, 4, 6, 5,0,1,1,1,0,1, 0, 6, 0,0,1);
        tbl[16] = mk(1, 5, 0, 6,0,1,1,1,0,0, 0, 0, 0,0,1);

        drive(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0));
        reset = 1'b0;
        #2;
        chk("reset_fwd_a", 32'(fwd_a), 32'd0);
        chk("reset_fwd_b", 32'(fwd_b), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_cnt", 32'(stall_cnt), 32'd0);
        do_reset();

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i]);
            #1;
            chk($sformatf("tbl%0d_stall", i), 32'(stall), 32'(tbl[i].e_stall));
            chk($sformatf("tbl%0d_rdb", i), 32'(rd_addr_b), 32'(tbl[i].e_rdb));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_fwd_a", i), 32'(fwd_a), 32'(tbl[i].e_fa));
            chk($sformatf("tbl%0d_fwd_b", i), 32'(fwd_b), 32'(tbl[i].e_fb));
            chk($sformatf("tbl%0d_cnt", i), 32'(stall_cnt), 32'(tbl[i].e_cnt));
        end

        // Asynchronous reset in the middle of a load-use stall.
        drive(mk(1,6,0,1,0,1,0,1,1,0, 0,0,0,0,0));
        @(posedge clk);
        #1;
        drive(mk(1,1,3,2,0,1,1,1,0,0, 0,0,0,0,0));
        #1;
        chk("pre_rst_stall", 32'(stall), 32'd1);
        chk("pre_rst_fwd_a", 32'(fwd_a), 32'd2);
        reset = 1'b0;
        #1;
        chk("async_rst_stall", 32'(stall), 32'd0);
        chk("async_rst_fwd_a", 32'(fwd_a), 32'd0);
        chk("async_rst_fwd_b", 32'(fwd_b), 32'd0);
        chk("async_rst_cnt", 32'(stall_cnt), 32'd0);
        do_reset();

        // Random traffic against the issue-slot model.
        begin
            logic       hold;
            logic       e_st, acc;
            logic [1:0] e_fa, e_fb;
            hold = 1'b0;
            for (int c = 0; c < 600; c++) begin
                if (!hold) begin
                    id_valid     = ($urandom_range(0, 9) < 8);
                    id_rn        = pick_reg();
                    id_rm        = pick_reg();
                    id_rd        = pick_reg();
                    id_reg2loc   = 1'($urandom_range(0, 1));
                    id_uses_a    = ($urandom_range(0, 9) < 8);
                    id_uses_b    = ($urandom_range(0, 9) < 6);
                    id_reg_write = ($urandom_range(0, 9) < 7);
                    id_mem_read  = ($urandom_range(0, 9) < 3);
                    flush        = ($urandom_range(0, 9) == 0);
                end
                #1;
                e_st = model_stall();
                chk("rnd_stall", 32'(stall), 32'(e_st));
                chk("rnd_rdb", 32'(rd_addr_b), 32'(id_reg2loc ? id_rd : id_rm));
                acc  = id_valid && !flush && !e_st;
                e_fa = acc ? sel_of(id_uses_a, id_rn) : 2'b00;
                e_fb = acc ? sel_of(id_uses_b, id_reg2loc ? id_rd : id_rm) : 2'b00;
                if (e_st && mcnt < (1 << CNTW) - 1) mcnt++;
                hist.push_back(acc ? slot_t'{1'b1, id_rd, id_reg_write, id_mem_read} : slot_t'('0));
                void'(hist.pop_front());
                @(posedge clk);
                #1;
                chk("rnd_fwd_a", 32'(fwd_a), 32'(e_fa));
                chk("rnd_fwd_b", 32'(fwd_b), 32'(e_fb));
                chk("rnd_cnt", 32'(stall_cnt), 32'(mcnt));
                hold = e_st;
            end
        end

        // Saturation: one stall per load/consumer pair.
        do_reset();
        ldv  = mk(1,0,0,1,0,0,0,1,1,0, 0,0,0,0,0);
        usev = mk(1,1,0,2,0,1,0,1,0,0, 0,0,0,0,0);
        for (int k = 0; k < (1 << CNTW) - 1; k++) begin
            drive(ldv);
            @(posedge clk);
            #1;
            drive(usev);
            @(posedge clk);
            #1;
        end
        chk("cnt_at_max", 32'(stall_cnt), 32'((1 << CNTW) - 1));
        for (int k = 0; k < 3; k++) begin
            drive(ldv);
            @(posedge clk);
            #1;
            drive(usev);
            #1;
            chk("sat_stall_active", 32'(stall), 32'd1);
            @(posedge clk);
            #1;
        end
        chk("cnt_saturated", 32'(stall_cnt), 32'((1 << CNTW) - 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Forwarding and load-use hazard controller for the 5-stage pipelined CPU.
- Tracks the destination register numbers of the instructions in the EX and MEM stages in its own shadow pipeline.
- Selects the second read-register address (Rm or Rd, chosen by Reg2Loc).
- Produces registered forwarding selects for the EX-stage operand muxes, plus a combinational stall for the IF/ID and PC.

Parameters:
AW, 5, register-address width
CNTW, 16, width of the saturating stall-event counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low; asserted (0) clears all state
id_valid  input  1  ID stage holds a real instruction
id_rn  input  AW  first source register
id_rm  input  AW  Rm field
id_rd  input  AW  Rd field (destination; also second source when id_reg2loc=1)
id_reg2loc  input  1  0: second source is Rm; 1: second source is Rd
id_uses_a  input  1  ID instruction reads Rn
id_uses_b  input  1  ID instruction reads the second source
id_reg_write  input  1  ID instruction writes id_rd
id_mem_read  input  1  ID instruction is a load
flush  input  1  taken branch; kill the ID instruction
rd_addr_b  output  AW  second register-file read address
fwd_a  output  2  EX operand-A select: 00 register file, 01 MEM/WB, 10 EX/MEM
fwd_b  output  2  EX operand-B select, same encoding as fwd_a
stall  output  1  hold PC and IF/ID; insert a bubble into EX
stall_cnt  output  CNTW  number of cycles with stall=1, saturating

Behaviour:
- rd_addr_b is combinational: id_reg2loc ? id_rd : id_rm.
- Shadow pipeline registers:
  - EX stage: ex_valid, ex_rd, ex_regw, ex_memrd.
  - MEM stage: mem_valid, mem_rd, mem_regw.
  - Every cycle, MEM takes the EX contents. EX takes the ID instruction when it is accepted; otherwise EX takes a bubble.
- ID instruction accepted: id_valid & !flush & !stall.
- Match rule, for src in {id_rn, rd_addr_b} gated by id_uses_a / id_uses_b:
  - EX match: ex_valid & ex_regw & ex_rd==src & src!=31.
  - MEM match: mem_valid & mem_regw & mem_rd==src & src!=31.
  - Register 31 (XZR) never matches.
- Forwarding selects, registered and updated at the same edge the instruction moves into EX:
  - EX match -> 10.
  - else MEM match -> 01.
  - else 00.
  - EX match wins when both match (younger producer).
  - A bubble or rejected instruction loads 00.
- Register file is write-before-read. There is no WB-stage bypass; a producer that has left MEM is never forwarded.
- stall (combinational) = id_valid & !flush & ex_valid & ex_memrd & ex_regw & (EX match on either used source).
- Stall sequence:
  - While stall=1, EX receives a bubble and the ID inputs are held by upstream.
  - Next cycle the load is in MEM, so stall drops and the selects register 01.
- Load-use latency: exactly one stall cycle.
- flush dominates stall: with flush=1, stall=0 and EX receives a bubble.
- stall_cnt increments on each clock with stall=1 and holds at all-ones.
- Reset (asynchronous, mid-operation included):
  - All valid bits, fwd_a, fwd_b and stall_cnt clear to 0 immediately.
  - stall is 0 while in reset because ex_valid=0.
  - rd_addr_b remains combinational.

Decomposition:
- Shared package cpu_pkg:
  - fwd_sel_t enum {FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10}.
  - Constant XZR = 5'd31.
- One sub-module, hazard_src_cmp:
  - Inputs: src, use, stage valid/regw/rd.
  - Output: match bit (includes the XZR exclusion).
  - Instantiated 4 times (2 sources x 2 stages).

Test Plan:
1. ADD X1 accepted, then ADD X2,X1,X3 in ID next cycle -> after next edge fwd_a=10, fwd_b=00, stall=0.
2. ADD X1, unrelated instruction, then SUB X4,X5,X1 -> fwd_b=01. Repeat with ADD X1 followed by ADD X1 -> fwd=10 (EX priority).
3. LDUR X1 in EX, ADD X2,X1,X1 in ID -> stall=1 for exactly one cycle, stall_cnt=1; next edge fwd_a=fwd_b=01.
4. Producer writes X31, consumer reads X31 -> fwd 00, no stall. STUR with reg2loc=1, rd=7, rm=9 -> rd_addr_b=7 and matches a pending X7 writer.
5. Load-use hazard with flush=1 in the same cycle -> stall=0; next cycle ex_valid=0 and fwd=00.
6. Assert reset during a stall cycle -> stall, fwd_a, fwd_b and stall_cnt go to 0 without a clock edge. Force stall for 2^CNTW+3 cycles -> stall_cnt holds at 16'hFFFF.
